// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite command master and the histogram core register map.
package axil_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_RESP
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [3:0] ADDR_CTRL   = 4'h0;
   localparam logic [3:0] ADDR_STATUS = 4'h4;
   localparam logic [3:0] ADDR_ERR    = 4'h8;

   localparam logic [1:0] STATUS_IDLE  = 2'd0;
   localparam logic [1:0] STATUS_BUSY  = 2'd1;
   localparam logic [1:0] STATUS_DONE  = 2'd2;
   localparam logic [1:0] STATUS_ERROR = 2'd3;

endpackage

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a register slave.
interface axil_cmd_master_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_timeout_cnt.sv
// Per-phase watchdog: down-counter reloaded on clr, expires when it reaches zero
// while enabled, i.e. on the TIMEOUT-th consecutive waiting cycle.
module axil_timeout_cnt #(
   parameter int TIMEOUT = 255,
   parameter int TO_BITS = $clog2(TIMEOUT+1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam logic [TO_BITS-1:0] LOAD = TO_BITS'(TIMEOUT-1);

   logic [TO_BITS-1:0] cnt;

   // Reload on clear, otherwise count down while a phase is waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= LOAD;
      end else if (clr) begin
         cnt <= LOAD;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = en && !clr && (cnt == '0);
endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator driven by a simple command/response port.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a command
// ST_WR      | AW and W offered, each tracked by its own done flag
// ST_WR_RESP | bready high, waiting for B
// ST_RD_ADDR | arvalid high, waiting for AR handshake
// ST_RD_DATA | rready high, waiting for R
// ST_RESP    | rsp_valid held with stable payload until rsp_ready
module axil_cmd_master
   import axil_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255,
   parameter int TO_BITS    = $clog2(TIMEOUT+1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,
   output logic                    busy,
   axil_cmd_master_if.master       axi
);
   state_t state, nxt_state;
   logic aw_done, nxt_aw_done, w_done, nxt_w_done;
   logic nxt_cmd_ready, nxt_busy, nxt_rsp_valid, nxt_rsp_timeout;
   logic [DATA_WIDTH-1:0] nxt_rsp_rdata;
   logic [1:0] nxt_rsp_resp;
   logic [ADDR_WIDTH-1:0] awaddr_q, nxt_awaddr, araddr_q, nxt_araddr;
   logic [DATA_WIDTH-1:0] wdata_q, nxt_wdata;
   logic [DATA_WIDTH/8-1:0] wstrb_q, nxt_wstrb;
   logic awvalid_q, nxt_awvalid, wvalid_q, nxt_wvalid, bready_q, nxt_bready;
   logic arvalid_q, nxt_arvalid, rready_q, nxt_rready;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wd_clr, wd_en, expired;

   assign aw_hs = awvalid_q && axi.awready;
   assign w_hs  = wvalid_q && axi.wready;
   assign b_hs  = bready_q && axi.bvalid;
   assign ar_hs = arvalid_q && axi.arready;
   assign r_hs  = rready_q && axi.rvalid;

   // Any handshake (or sitting in IDLE) restarts the wait budget, so phase entries reload it.
   assign wd_clr = (state == ST_IDLE) || aw_hs || w_hs || b_hs || ar_hs || r_hs;
   assign wd_en  = state inside {ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA};

   axil_timeout_cnt #(.TIMEOUT(TIMEOUT), .TO_BITS(TO_BITS)) u_wd (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (expired)
   );

   // Next-state and next registered outputs.
   always_comb begin
      nxt_state       = state;
      nxt_aw_done     = aw_done;
      nxt_w_done      = w_done;
      nxt_rsp_valid   = rsp_valid;
      nxt_rsp_rdata   = rsp_rdata;
      nxt_rsp_resp    = rsp_resp;
      nxt_rsp_timeout = rsp_timeout;
      nxt_awaddr      = awaddr_q;
      nxt_wdata       = wdata_q;
      nxt_wstrb       = wstrb_q;
      nxt_araddr      = araddr_q;
      nxt_awvalid     = awvalid_q;
      nxt_wvalid      = wvalid_q;
      nxt_bready      = bready_q;
      nxt_arvalid     = arvalid_q;
      nxt_rready      = rready_q;
      unique case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_addr[1:0] != 2'b00) begin
                  nxt_state       = ST_RESP;
                  nxt_rsp_valid   = 1'b1;
                  nxt_rsp_rdata   = '0;
                  nxt_rsp_resp    = RESP_SLVERR;
                  nxt_rsp_timeout = 1'b0;
               end else if (cmd_write) begin
                  nxt_state   = ST_WR;
                  nxt_awaddr  = cmd_addr;
                  nxt_wdata   = cmd_wdata;
                  nxt_wstrb   = cmd_wstrb;
                  nxt_awvalid = 1'b1;
                  nxt_wvalid  = 1'b1;
                  nxt_aw_done = 1'b0;
                  nxt_w_done  = 1'b0;
               end else begin
                  nxt_state   = ST_RD_ADDR;
                  nxt_araddr  = cmd_addr;
                  nxt_arvalid = 1'b1;
               end
            end
         end
         ST_WR: begin
            if (aw_hs) begin
               nxt_awvalid = 1'b0;
               nxt_aw_done = 1'b1;
            end
            if (w_hs) begin
               nxt_wvalid = 1'b0;
               nxt_w_done = 1'b1;
            end
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
               nxt_state  = ST_WR_RESP;
               nxt_bready = 1'b1;
            end
         end
         ST_WR_RESP: begin
            if (b_hs) begin
               nxt_state       = ST_RESP;
               nxt_bready      = 1'b0;
               nxt_rsp_valid   = 1'b1;
               nxt_rsp_rdata   = '0;
               nxt_rsp_resp    = axi.bresp;
               nxt_rsp_timeout = 1'b0;
            end
         end
         ST_RD_ADDR: begin
            if (ar_hs) begin
               nxt_state   = ST_RD_DATA;
               nxt_arvalid = 1'b0;
               nxt_rready  = 1'b1;
            end
         end
         ST_RD_DATA: begin
            if (r_hs) begin
               nxt_state       = ST_RESP;
               nxt_rready      = 1'b0;
               nxt_rsp_valid   = 1'b1;
               nxt_rsp_rdata   = axi.rdata;
               nxt_rsp_resp    = axi.rresp;
               nxt_rsp_timeout = 1'b0;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               nxt_state       = ST_IDLE;
               nxt_rsp_valid   = 1'b0;
               nxt_rsp_rdata   = '0;
               nxt_rsp_resp    = RESP_OKAY;
               nxt_rsp_timeout = 1'b0;
            end
         end
         default: nxt_state = ST_IDLE;
      endcase
      // Watchdog abort: never coincides with a handshake, so it can override the case above.
      if (expired) begin
         nxt_state       = ST_RESP;
         nxt_awvalid     = 1'b0;
         nxt_wvalid      = 1'b0;
         nxt_bready      = 1'b0;
         nxt_arvalid     = 1'b0;
         nxt_rready      = 1'b0;
         nxt_rsp_valid   = 1'b1;
         nxt_rsp_rdata   = '0;
         nxt_rsp_resp    = RESP_SLVERR;
         nxt_rsp_timeout = 1'b1;
      end
      nxt_cmd_ready = (nxt_state == ST_IDLE);
      nxt_busy      = (nxt_state != ST_IDLE);
   end

   // State and registered outputs; reset drops every valid at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         cmd_ready   <= 1'b1;
         busy        <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_resp    <= RESP_OKAY;
         rsp_timeout <= 1'b0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         araddr_q    <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
      end else begin
         state       <= nxt_state;
         aw_done     <= nxt_aw_done;
         w_done      <= nxt_w_done;
         cmd_ready   <= nxt_cmd_ready;
         busy        <= nxt_busy;
         rsp_valid   <= nxt_rsp_valid;
         rsp_rdata   <= nxt_rsp_rdata;
         rsp_resp    <= nxt_rsp_resp;
         rsp_timeout <= nxt_rsp_timeout;
         awaddr_q    <= nxt_awaddr;
         wdata_q     <= nxt_wdata;
         wstrb_q     <= nxt_wstrb;
         araddr_q    <= nxt_araddr;
         awvalid_q   <= nxt_awvalid;
         wvalid_q    <= nxt_wvalid;
         bready_q    <= nxt_bready;
         arvalid_q   <= nxt_arvalid;
         rready_q    <= nxt_rready;
      end
   end

   assign axi.awaddr  = awaddr_q;
   assign axi.awvalid = awvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;
   assign axi.araddr  = araddr_q;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;
endmodule
